// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared FP32 datapath types and field constants
// Contents: FSM state enum, IEEE-754 binary32 field constants, flag bit
// indices and the unpacked-operand record produced by fp32_unpack.
package fp32_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        UNPACK = 3'd1,
        DIVIDE = 3'd2,
        ROUND  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF  = 32'h7F80_0000;

    // bit positions inside flags = {invalid, div_by_zero, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 4;
    localparam int FLAG_DIV_ZERO  = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] sig;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } fp_unpacked_t;

endpackage

// File: rtl/fp32_seq_divider_if.sv
// rtl/fp32_seq_divider_if.sv - start/busy/done operand and result bundle for the FP32 divider
// Signals: start, a, b (requester -> divider); busy, done, result and, when
// FP32DIV_FLAGS_EN is defined, flags (divider -> requester).
// Modports: master = requester side, slave = divider side.
interface fp32_seq_divider_if;

    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

`ifdef FP32DIV_FLAGS_EN
    logic [4:0]  flags;

    modport master (output start, a, b, input busy, done, result, flags);
    modport slave  (input start, a, b, output busy, done, result, flags);
`else
    modport master (output start, a, b, input busy, done, result);
    modport slave  (input start, a, b, output busy, done, result);
`endif

endinterface

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - combinational binary32 field extraction and classification
// Ports: x (binary32 operand in), u (fp_unpacked_t out).
// Exponent 0 is classified as zero whatever the fraction holds, so
// subnormals are flushed here and never reach the arithmetic.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]  x,
    output fp_unpacked_t u
);

    logic exp_zero;
    logic exp_ones;
    logic frac_zero;

    always_comb begin
        exp_zero  = (x[30:23] == 8'h00);
        exp_ones  = (x[30:23] == 8'(EXP_MAX));
        frac_zero = (x[22:0] == 23'h0);

        u.sign    = x[31];
        u.exp     = x[30:23];
        u.sig     = {1'b1, x[22:0]};
        u.is_zero = exp_zero;
        u.is_inf  = exp_ones && frac_zero;
        u.is_nan  = exp_ones && !frac_zero;
    end

endmodule

// File: rtl/fp32_seq_divider.sv
// rtl/fp32_seq_divider.sv - iterative IEEE-754 binary32 divider, result = a / b
// Ports: clk, rst_n (synchronous, active-low), bus (fp32_seq_divider_if.slave:
// start, a, b, busy, done, result, optional flags).
// Parameter RADIX_LOG2 (1 or 2): quotient bits retired per DIVIDE cycle.
// Macro FP32DIV_FLAGS_EN: when defined, the flags output and its registers exist.
// Restoring division of 26 quotient bits (24 significand + guard + round),
// round-to-nearest-even, subnormal inputs and results flushed to zero.
module fp32_seq_divider
    import fp32_pkg::*;
#(
    parameter int RADIX_LOG2 = 1
)(
    input  logic               clk,
    input  logic               rst_n,
    fp32_seq_divider_if.slave  bus
);

    localparam int                 N      = 26 / RADIX_LOG2;
    localparam logic [4:0]         LAST   = 5'(N - 1);
    localparam logic signed [9:0]  BIAS10 = 10'(EXP_BIAS);
    localparam logic signed [9:0]  MAX10  = 10'(EXP_MAX);

    state_t state_q, state_d;

    logic [31:0]        a_q, b_q;
    fp_unpacked_t       ua, ub;

    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [23:0]        div_q;
    logic [25:0]        rem_q;
    logic [25:0]        quo_q;
    logic [4:0]         cnt_q;
    logic [31:0]        result_q;

    fp32_unpack u_unpack_a (.x(a_q), .u(ua));
    fp32_unpack u_unpack_b (.x(b_q), .u(ub));

    // ---------------- special operands and normal setup (UNPACK) ----------------
    logic               sign_ab;
    logic               is_special;
    logic [31:0]        special_res;
    logic               ma_lt;
    logic signed [9:0]  exp_init;
    logic [25:0]        rem_init;
`ifdef FP32DIV_FLAGS_EN
    logic [4:0]         special_flags;
`endif

    always_comb begin
        sign_ab     = ua.sign ^ ub.sign;
        is_special  = 1'b1;
        special_res = QNAN;
`ifdef FP32DIV_FLAGS_EN
        special_flags = '0;
`endif
        if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
            special_res = QNAN;
`ifdef FP32DIV_FLAGS_EN
            special_flags[FLAG_INVALID] = 1'b1;
`endif
        end else if (ub.is_zero && !ua.is_inf) begin
            special_res = POS_INF | {sign_ab, 31'h0};
`ifdef FP32DIV_FLAGS_EN
            special_flags[FLAG_DIV_ZERO] = 1'b1;
`endif
        end else if (ua.is_inf) begin
            // inf / finite, including inf / 0, is a quiet signed infinity
            special_res = POS_INF | {sign_ab, 31'h0};
        end else if (ub.is_inf || ua.is_zero) begin
            special_res = {sign_ab, 31'h0};
        end else begin
            is_special = 1'b0;
        end

        // Pre-shift the dividend so the quotient lands in [1,2): the first
        // quotient bit retired is then always the integer 1.
        ma_lt    = (ua.sig < ub.sig);
        exp_init = $signed({2'b00, ua.exp}) - $signed({2'b00, ub.exp}) + BIAS10
                   - (ma_lt ? 10'sd1 : 10'sd0);
        rem_init = ma_lt ? {1'b0, ua.sig, 1'b0} : {2'b00, ua.sig};
    end

    // ---------------- restoring division step(s) (DIVIDE) ----------------
    // The remainder stays below 2*divisor < 2^25, so 26 bits never overflow.
    logic [25:0] step_rem;
    logic [25:0] step_quo;

    always_comb begin
        step_rem = rem_q;
        step_quo = quo_q;
        for (int i = 0; i < RADIX_LOG2; i++) begin
            if (step_rem >= {2'b00, div_q}) begin
                step_rem = step_rem - {2'b00, div_q};
                step_quo = {step_quo[24:0], 1'b1};
            end else begin
                step_quo = {step_quo[24:0], 1'b0};
            end
            step_rem = {step_rem[24:0], 1'b0};
        end
    end

    // ---------------- round to nearest even and range check (ROUND) ----------------
    // quo_q[25] integer bit, [24:2] fraction, [1] guard, [0] round.
    logic               guard_bit;
    logic               round_bit;
    logic               sticky_bit;
    logic               round_up;
    logic [24:0]        sig_r;
    logic signed [9:0]  exp_r;
    logic [22:0]        frac_r;
    logic [31:0]        round_res;
`ifdef FP32DIV_FLAGS_EN
    logic [4:0]         round_flags;
`endif

    always_comb begin
        guard_bit  = quo_q[1];
        round_bit  = quo_q[0];
        sticky_bit = |rem_q;
        round_up   = guard_bit && (round_bit || sticky_bit || quo_q[2]);
        sig_r      = {1'b0, quo_q[25:2]} + {24'h0, round_up};
        // carry out of the significand: value became exactly 2.0
        exp_r      = exp_q + (sig_r[24] ? 10'sd1 : 10'sd0);
        frac_r     = sig_r[24] ? sig_r[23:1] : sig_r[22:0];
`ifdef FP32DIV_FLAGS_EN
        round_flags = '0;
        round_flags[FLAG_INEXACT] = guard_bit || round_bit || sticky_bit;
`endif
        if (exp_r >= MAX10) begin
            round_res = POS_INF | {sign_q, 31'h0};
`ifdef FP32DIV_FLAGS_EN
            round_flags[FLAG_OVERFLOW] = 1'b1;
            round_flags[FLAG_INEXACT]  = 1'b1;
`endif
        end else if (exp_r <= 10'sd0) begin
            round_res = {sign_q, 31'h0};
`ifdef FP32DIV_FLAGS_EN
            round_flags[FLAG_UNDERFLOW] = 1'b1;
            round_flags[FLAG_INEXACT]   = 1'b1;
`endif
        end else begin
            round_res = {sign_q, exp_r[7:0], frac_r};
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = UNPACK;
            UNPACK:  state_d = is_special ? DONE : DIVIDE;
            DIVIDE:  if (cnt_q == LAST) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= 32'h0;
            cnt_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q <= bus.a;
                        b_q <= bus.b;
                    end
                end
                UNPACK: begin
                    if (is_special) begin
                        result_q <= special_res;
                    end else begin
                        sign_q <= sign_ab;
                        exp_q  <= exp_init;
                        div_q  <= ub.sig;
                        rem_q  <= rem_init;
                        quo_q  <= 26'h0;
                        cnt_q  <= 5'd0;
                    end
                end
                DIVIDE: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q + 5'd1;
                end
                ROUND:   result_q <= round_res;
                default: ;
            endcase
        end
    end

`ifdef FP32DIV_FLAGS_EN
    logic [4:0] flags_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 5'h0;
        end else if (state_q == UNPACK && is_special) begin
            flags_q <= special_flags;
        end else if (state_q == ROUND) begin
            flags_q <= round_flags;
        end
    end

    assign bus.flags = flags_q;
`endif

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_fp32_seq_divider.sv
// tb/tb_fp32_seq_divider.sv - directed self-checking bench for fp32_seq_divider (radix 2 and 4 instances)
module tb_fp32_seq_divider;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fp32_seq_divider_if bus1 ();
    fp32_seq_divider_if bus2 ();

    fp32_seq_divider #(.RADIX_LOG2(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    fp32_seq_divider #(.RADIX_LOG2(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [4:0]  flg;
        bit          special;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (sel == 1) begin
            bus1.start = s; bus1.a = a; bus1.b = b;
        end else begin
            bus2.start = s; bus2.a = a; bus2.b = b;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 1) ? bus1.busy : bus2.busy;
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 1) ? bus1.done : bus2.done;
    endfunction

    function automatic logic [31:0] get_result(input int sel);
        return (sel == 1) ? bus1.result : bus2.result;
    endfunction

`ifdef FP32DIV_FLAGS_EN
    function automatic logic [4:0] get_flags(input int sel);
        return (sel == 1) ? bus1.flags : bus2.flags;
    endfunction
`endif

    // Issue one operation from an idle divider; cycle 0 is the cycle start is
    // presented, so lat counts cycles until done is seen high.
    task automatic run_op(input int sel, input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic [4:0] exp_flg, input int exp_lat);
        int lat;
        bit busy_ok;
        drive(sel, 1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, 32'h0, 32'h0);
        lat = 1;
        busy_ok = 1'b1;
        while (1) begin
            if (!get_busy(sel)) busy_ok = 1'b0;
            if (get_done(sel) || lat >= 60) break;
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, get_result(sel), exp_res);
        check({tag, "_busy_during"}, {31'h0, busy_ok}, 32'h1);
`ifdef FP32DIV_FLAGS_EN
        check({tag, "_flags"}, {27'h0, get_flags(sel)}, {27'h0, exp_flg});
`else
        if (exp_flg != exp_flg) check({tag, "_unreached"}, 32'h0, 32'h1);
`endif
        @(negedge clk);
        check({tag, "_busy_after"}, {31'h0, get_busy(sel)}, 32'h0);
        check({tag, "_result_held"}, get_result(sel), exp_res);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen_done;

        //          a             b             result        flags     special
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 1'b0}; // 6/2
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 1'b0}; // 1/3
        vecs[2]  = '{32'h3F800000, 32'h80000000, 32'hFF800000, 5'b01000, 1'b1}; // 1/-0
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 1'b1}; // 0/0
        vecs[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 1'b0}; // overflow
        vecs[5]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 5'b00011, 1'b0}; // underflow
        vecs[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000, 1'b1}; // NaN/1
        vecs[7]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 1'b1}; // inf/inf
        vecs[8]  = '{32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000, 1'b1}; // inf/0
        vecs[9]  = '{32'hC0000000, 32'h7F800000, 32'h80000000, 5'b00000, 1'b1}; // -2/inf
        vecs[10] = '{32'h00400000, 32'hC0000000, 32'h80000000, 5'b00000, 1'b1}; // subnormal/-2
        vecs[11] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 5'b00000, 1'b0}; // -6/2
        vecs[12] = '{32'h3F800000, 32'h3F7FFFFF, 32'h3F800001, 5'b00001, 1'b0}; // guard+sticky round up
        vecs[13] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 5'b00000, 1'b1}; // inf/2

        rst_n = 1'b0;
        drive(1, 1'b0, 32'h0, 32'h0);
        drive(2, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy1", {31'h0, bus1.busy}, 32'h0);
        check("reset_done1", {31'h0, bus1.done}, 32'h0);
        check("reset_result1", bus1.result, 32'h0);
        check("reset_busy2", {31'h0, bus2.busy}, 32'h0);
        check("reset_result2", bus2.result, 32'h0);
`ifdef FP32DIV_FLAGS_EN
        check("reset_flags1", {27'h0, bus1.flags}, 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        for (int sel = 1; sel <= 2; sel++) begin
            for (int i = 0; i < 14; i++) begin
                run_op(sel, $sformatf("r%0d_v%0d", sel, i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg,
                       vecs[i].special ? 2 : (sel == 1 ? 29 : 16));
            end
        end

        // start during busy and during DONE is ignored; start right after DONE is taken
        drive(1, 1'b1, 32'h40C00000, 32'h40000000);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'h0, 32'h0);
        cyc = 1;
        repeat (4) begin @(negedge clk); cyc++; end
        drive(1, 1'b1, 32'h3F800000, 32'h40400000);
        @(negedge clk);
        cyc++;
        drive(1, 1'b0, 32'h0, 32'h0);
        while (!bus1.done && cyc < 60) begin @(negedge clk); cyc++; end
        check("ign_busy_latency", 32'(cyc), 32'd29);
        check("ign_busy_result", bus1.result, 32'h40400000);
        drive(1, 1'b1, 32'h3F800000, 32'h3F800000);
        @(negedge clk);
        check("ign_done_busy", {31'h0, bus1.busy}, 32'h0);
        check("ign_done_result", bus1.result, 32'h40400000);
        drive(1, 1'b1, 32'h3F800000, 32'h40400000);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'h0, 32'h0);
        check("accept_after_done_busy", {31'h0, bus1.busy}, 32'h1);
        cyc = 1;
        while (!bus1.done && cyc < 60) begin @(negedge clk); cyc++; end
        check("accept_after_done_latency", 32'(cyc), 32'd29);
        check("accept_after_done_result", bus1.result, 32'h3EAAAAAB);
        @(negedge clk);

        // reset in DIVIDE iteration 10 abandons the operation
        drive(1, 1'b1, 32'h40C00000, 32'h40000000);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'h0, 32'h0);
        cyc = 1;
        while (cyc < 12) begin @(negedge clk); cyc++; end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_busy", {31'h0, bus1.busy}, 32'h0);
        check("midreset_done", {31'h0, bus1.done}, 32'h0);
        check("midreset_result", bus1.result, 32'h0);
`ifdef FP32DIV_FLAGS_EN
        check("midreset_flags", {27'h0, bus1.flags}, 32'h0);
`endif
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus1.done) seen_done = 1'b1;
        end
        check("midreset_no_done", {31'h0, seen_done}, 32'h0);
        run_op(1, "after_reset", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 29);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
